inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
Encodes field-level instruction requests into 32-bit instruction words, then writes them one at a time into the instruction memory write port. The words use the formats our control unit decodes: R-type, LW and SW. It sits between the testbench or boot-loader host and the instruction memory, ahead of the pipeline. It is the encoder counterpart of the decode stage.

Parameters:
ADDR_W, 6, instruction memory address width; depth is 2**ADDR_W words.
BASE_ADDR, 0, first memory address written after start.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a load session. Honoured only in IDLE or DONE.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request.
in_kind  in  2  00 R-type, 01 LW, 10 SW, 11 illegal.
in_rs  in  5  source register.
in_rt  in  5  second source (R-type/SW) or load destination (LW).
in_rd  in  5  R-type destination.
in_alu  in  4  R-type ALU control; placed in func[3:0].
in_cin  in  1  R-type carry-in; placed in func[4].
in_imm  in  16  LW/SW offset.
in_last  in  1  marks the final request of the session.
mem_we  out  1  instruction memory write strobe.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  32  encoded instruction.
busy  out  1  high in ACCEPT, WRITE and PAD.
done  out  1  high in DONE.
err  out  1  sticky: an illegal kind was received this session.
count  out  ADDR_W+1  number of real instructions written this session.

Behaviour:
- Reset values (all outputs): in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, count=0. FSM=IDLE.
- Reset asserted mid-session: everything returns to reset values immediately (async), mem_we drops at once, and the session is abandoned.
- FSM states: IDLE, ACCEPT, WRITE, PAD (only when the optional feature is compiled in), DONE.
- IDLE -> ACCEPT on start.
- DONE -> ACCEPT on start. On this transition: mem_addr=BASE_ADDR, count=0, err=0.
- start in any other state is ignored.
- ACCEPT:
  - in_ready=1.
  - A handshake is in_valid and in_ready high at a rising edge.
  - On handshake with a legal kind: register the encoded word into mem_wdata and go to WRITE.
- Encoding:
  - R-type = {6'b000000, rs, rt, rd, 5'b00000, 1'b1, cin, alu}.
  - LW = {6'b100011, rs, rt, imm}.
  - SW = {6'b101011, rs, rt, imm}.
  - Unused request fields are ignored.
- Illegal kind (11):
  - Set err and write nothing.
  - If in_last, go to end-of-session (see below); otherwise stay in ACCEPT.
- WRITE:
  - Lasts exactly one cycle with mem_we=1, in_ready=0. Latency is handshake edge N -> mem_we high in cycle N+1.
  - At the end of WRITE: count += 1.
  - If the word was last, or mem_addr == 2**ADDR_W-1 (memory full), go to end-of-session.
  - Otherwise mem_addr += 1 and return to ACCEPT.
  - When full, any remaining requests are left unaccepted.
- Throughput: at most one instruction per 2 cycles.
- mem_addr never wraps within a session; count saturates at 2**ADDR_W.
- in_last is sampled together with the handshake.

Optional Feature:
Macro INST_ENCODER_NOP_PAD_EN.
- Defined: end-of-session enters PAD.
  - PAD writes 32'h00000000 (NOP) to each address from the last written address + 1 up to 2**ADDR_W-1, one write per cycle with mem_we=1.
  - Then go to DONE.
  - count excludes pad writes.
  - If the last real write was at the top address, PAD is skipped.
  - If an illegal last request ends the session, padding starts at the current mem_addr. This includes the case where no real write occurred.
- Not defined: end-of-session goes directly to DONE. There is no PAD state, and no memory writes occur after the final real instruction.

Test Plan:
- Reset then start; R-type rs=1 rt=2 rd=3 alu=0010 cin=0 last=1 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221822; then done=1, count=1.
- Start; LW rs=0 rt=5 imm=0x0004, then SW rs=2 rt=7 imm=0x0010 last=1 -> writes 0x8C050004 at addr 0 and 0xAC470010 at addr 1; count=2; in_ready low during each WRITE cycle.
- in_kind=11 without last, then a legal R-type with last -> err=1, only one write (addr 0), count=1. A following start clears err.
- ADDR_W=2, five valid requests with no last -> four writes at addr 0..3, DONE after the 4th, 5th never accepted (in_ready=0), count=4.
- Assert rst during the WRITE cycle -> mem_we=0 immediately and all outputs at reset values. A new start restarts at BASE_ADDR.
- With INST_ENCODER_NOP_PAD_EN, ADDR_W=3, two instructions, last -> six extra writes of 0x00000000 at addr 2..7, then done=1, count=2. Without the macro, done follows immediately after addr 1.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// -----------------------------------------------------------------------------
// inst_encoder_loader
//
// Turns field-level instruction requests (R-type, LW, SW) into 32-bit
// instruction words and writes them one per session slot into the
// instruction memory write port, starting at BASE_ADDR.
//
// Optional feature (macro INST_ENCODER_NOP_PAD_EN): when defined, the end of
// a session fills every address above the last written one with NOP
// (32'h0) before reporting done.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, begins a session (IDLE/DONE only)
//   in_valid/in_ready   request handshake
//   in_kind             00 R-type, 01 LW, 10 SW, 11 illegal
//   in_rs,in_rt,in_rd   register fields
//   in_alu,in_cin       R-type func[3:0] and func[4]
//   in_imm              LW/SW offset
//   in_last             final request of the session
//   mem_we/addr/wdata   instruction memory write port
//   busy                session in progress
//   done                session finished
//   err                 sticky illegal-kind flag for this session
//   count               real instructions written this session
// -----------------------------------------------------------------------------
module inst_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [3:0]        in_alu,
    input  logic              in_cin,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3
`ifdef INST_ENCODER_NOP_PAD_EN
        , S_PAD  = 3'd4
`endif
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              err_reg, err_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              last_reg, last_next;
    logic [31:0]       enc_word;

    // Instruction word formats understood by the control unit.
    always_comb begin
        enc_word = 32'h0;
        case (in_kind)
            2'b00:   enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 1'b1, in_cin, in_alu};
            2'b01:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
            default: enc_word = {6'b101011, in_rs, in_rt, in_imm};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= BASE;
            wdata_reg <= 32'h0;
            err_reg   <= 1'b0;
            count_reg <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            err_reg   <= err_next;
            count_reg <= count_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        err_next   = err_reg;
        count_next = count_reg;
        last_next  = last_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_ACCEPT;
                    addr_next  = BASE;
                    count_next = '0;
                    err_next   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (in_kind == 2'b11) begin
                        err_next = 1'b1;
                        if (in_last) begin
`ifdef INST_ENCODER_NOP_PAD_EN
                            // Nothing was written at addr_reg yet, so the
                            // pad run starts right here.
                            state_next = S_PAD;
                            wdata_next = 32'h0;
`else
                            state_next = S_DONE;
`endif
                        end
                    end else begin
                        wdata_next = enc_word;
                        last_next  = in_last;
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (count_reg != COUNT_MAX) begin
                    count_next = count_reg + (ADDR_W+1)'(1);
                end
                if (last_reg || addr_reg == TOP_ADDR) begin
`ifdef INST_ENCODER_NOP_PAD_EN
                    if (addr_reg == TOP_ADDR) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_PAD;
                        addr_next  = addr_reg + ADDR_W'(1);
                        wdata_next = 32'h0;
                    end
`else
                    state_next = S_DONE;
`endif
                end else begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = S_ACCEPT;
                end
            end
`ifdef INST_ENCODER_NOP_PAD_EN
            S_PAD: begin
                if (addr_reg == TOP_ADDR) begin
                    state_next = S_DONE;
                end else begin
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from state so an asynchronous reset clears them
    // (mem_we in particular) immediately.
    always_comb begin
        in_ready = (state_reg == S_ACCEPT);
        mem_we   = (state_reg == S_WRITE);
        busy     = (state_reg == S_ACCEPT) || (state_reg == S_WRITE);
`ifdef INST_ENCODER_NOP_PAD_EN
        mem_we   = mem_we || (state_reg == S_PAD);
        busy     = busy   || (state_reg == S_PAD);
`endif
        done     = (state_reg == S_DONE);
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign err       = err_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_inst_encoder_loader.sv
module tb_inst_encoder_loader;

    localparam int AW   = 3;
    localparam int BASE = 0;
    localparam int TOP  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = 2'b00;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
    logic [3:0]    in_alu = '0;
    logic          in_cin = 1'b0;
    logic [15:0]   in_imm = '0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy, done, err;
    logic [AW:0]   count;

    inst_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_alu(in_alu),
        .in_cin(in_cin), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  alu;
        logic        cin;
        logic [15:0] imm;
        logic        last;
    } req_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    req_t sess[$];
    wr_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_nacc, exp_cnt;
    bit   exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input int kind, input int rs, input int rt, input int rd,
                                input int alu, input int cin, input int imm, input int last);
        req_t r;
        r.kind = 2'(kind); r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.alu = 4'(alu); r.cin = 1'(cin); r.imm = 16'(imm); r.last = 1'(last);
        return r;
    endfunction

    // Instruction word by field arithmetic: opcode at bit 26, rs 21, rt 16,
    // rd 11, func = 32 + 16*cin + alu for R-type; LW opcode 35, SW opcode 43.
    function automatic logic [31:0] encode(input req_t r);
        int w;
        if (r.kind == 2'd0)
            w = (int'(r.rs) << 21) + (int'(r.rt) << 16) + (int'(r.rd) << 11)
              + 32 + int'(r.cin) * 16 + int'(r.alu);
        else
            w = ((r.kind == 2'd1 ? 35 : 43) << 26) + (int'(r.rs) << 21)
              + (int'(r.rt) << 16) + int'(r.imm);
        return 32'(w);
    endfunction

    // Reference: walk the session's requests and list every memory write.
    task automatic model_session();
        int  addr = BASE;
        bit  ended = 0;
        bit  by_write = 0;
        wr_t w;
        exp_nacc = 0; exp_cnt = 0; exp_err = 0;
        foreach (sess[i]) begin
            if (ended) break;
            exp_nacc++;
            if (sess[i].kind == 2'd3) begin
                exp_err = 1;
                if (sess[i].last) ended = 1;
            end else begin
                w.addr = addr; w.data = encode(sess[i]);
                exp_q.push_back(w);
                exp_cnt++;
                if (sess[i].last || addr == TOP) begin
                    ended = 1; by_write = 1;
                end else begin
                    addr++;
                end
            end
        end
`ifdef INST_ENCODER_NOP_PAD_EN
        if (ended) begin
            for (int a = (by_write ? addr + 1 : addr); a <= TOP; a++) begin
                w.addr = a; w.data = 32'h0;
                exp_q.push_back(w);
            end
        end
`endif
    endtask

    // Monitor: every observed write must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_we) begin
                chk("wr_ready_low", 32'(in_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] write addr=%0d data=0x%08h (exp addr=%0d data=0x%08h)",
                             mem_addr, mem_wdata, e.addr, e.data);
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic drive(input req_t r);
        in_kind = r.kind; in_rs = r.rs; in_rt = r.rt; in_rd = r.rd;
        in_alu = r.alu; in_cin = r.cin; in_imm = r.imm; in_last = r.last;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), BASE);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_count"}, 32'(count), 0);
    endtask

    task automatic run_session(input string name);
        int k;
        model_session();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({name, "_start_ready"}, 32'(in_ready), 1);
        chk({name, "_start_err"}, 32'(err), 0);
        chk({name, "_start_count"}, 32'(count), 0);
        for (int i = 0; i < exp_nacc; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive(sess[i]);
            in_valid = 1'b1;
            k = 0;
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) begin
                chk({name, "_hs_timeout"}, 32'(in_ready), 1);
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            $display("[TB] %s req %0d kind=%0d last=%0d accepted", name, i, sess[i].kind, sess[i].last);
            if (sess[i].kind == 2'd3) begin
                chk({name, "_err_set"}, 32'(err), 1);
            end else begin
                chk({name, "_latency_we"}, 32'(mem_we), 1);
                chk({name, "_write_ready"}, 32'(in_ready), 0);
            end
        end
        if (exp_nacc < sess.size()) begin
            // Requests left over once memory is full must never be taken.
            drive(sess[exp_nacc]);
            in_valid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                chk({name, "_full_no_ready"}, 32'(in_ready), 0);
            end
            in_valid = 1'b0;
        end
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done"}, 32'(done), 1);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_count"}, 32'(count), 32'(exp_cnt));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_writes_left"}, 32'(exp_q.size()), 0);
        $display("[TB] session %s count=%0d err=%0d", name, count, err);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #1;
        check_reset_vals("rst_async");
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Single R-type word: 0x00221822 at address 0.
        sess.delete();
        sess.push_back(mk(0, 1, 2, 3, 2, 0, 0, 1));
        run_session("rtype");

        // LW then SW: 0x8C050004 at 0, 0xAC470010 at 1.
        sess.delete();
        sess.push_back(mk(1, 0, 5, 0, 0, 0, 16'h0004, 0));
        sess.push_back(mk(2, 2, 7, 0, 0, 0, 16'h0010, 1));
        run_session("lw_sw");

        // Illegal kind, then a legal last request.
        sess.delete();
        sess.push_back(mk(3, 9, 9, 9, 9, 1, 16'hFFFF, 0));
        sess.push_back(mk(0, 4, 5, 6, 15, 1, 0, 1));
        run_session("illegal");

        // Illegal kind carrying last ends the session with nothing written.
        sess.delete();
        sess.push_back(mk(3, 1, 1, 1, 1, 0, 0, 1));
        run_session("illegal_last");

        // More requests than memory words, none marked last.
        sess.delete();
        for (int i = 0; i < TOP + 2; i++)
            sess.push_back(mk(i % 3, i, i + 1, i + 2, i, i & 1, i * 3, 0));
        run_session("full");

        // Reset in the middle of a WRITE cycle.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        drive(mk(0, 1, 2, 3, 4, 0, 0, 0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrst_we_before", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();

        sess.delete();
        sess.push_back(mk(2, 3, 4, 0, 0, 0, 16'h1234, 1));
        run_session("after_rst");

        for (int s = 0; s < 12; s++) begin
            int n;
            sess.delete();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                int kd;
                kd = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
                sess.push_back(mk(kd, $urandom_range(0, 31), $urandom_range(0, 31),
                                  $urandom_range(0, 31), $urandom_range(0, 15),
                                  $urandom_range(0, 1), $urandom_range(0, 65535),
                                  (i == n - 1) ? 1 : 0));
            end
            run_session($sformatf("rand%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
